// File: rtl/vermibus_if.sv
// Bus bundle between the Vermicel core (ibus/dbus), vermibus_arbiter and the memory side.
// slave: arbiter view; master: core+memory environment view.
interface vermibus_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

   logic                  ibus_valid;
   logic [ADDR_WIDTH-1:0] ibus_address;
   logic [DATA_WIDTH-1:0] ibus_rdata;
   logic                  ibus_ready;

   logic                  dbus_valid;
   logic [ADDR_WIDTH-1:0] dbus_address;
   logic [STRB_WIDTH-1:0] dbus_wstrobe;
   logic [DATA_WIDTH-1:0] dbus_wdata;
   logic [DATA_WIDTH-1:0] dbus_rdata;
   logic                  dbus_ready;
   logic                  dbus_irq;

   logic                  mem_valid;
   logic [ADDR_WIDTH-1:0] mem_address;
   logic [STRB_WIDTH-1:0] mem_wstrobe;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  mem_ready;
   logic                  mem_irq;

   modport slave (
      input  ibus_valid, ibus_address,
      output ibus_rdata, ibus_ready,
      input  dbus_valid, dbus_address, dbus_wstrobe, dbus_wdata,
      output dbus_rdata, dbus_ready, dbus_irq,
      output mem_valid, mem_address, mem_wstrobe, mem_wdata,
      input  mem_rdata, mem_ready, mem_irq
   );

   modport master (
      output ibus_valid, ibus_address,
      input  ibus_rdata, ibus_ready,
      output dbus_valid, dbus_address, dbus_wstrobe, dbus_wdata,
      input  dbus_rdata, dbus_ready, dbus_irq,
      input  mem_valid, mem_address, mem_wstrobe, mem_wdata,
      output mem_rdata, mem_ready, mem_irq
   );
endinterface

// File: rtl/vermibus_arbiter.sv
// Locking arbiter merging the core's ibus and dbus onto one memory bus, zero added latency.
// Define VERMIBUS_ARBITER_ROUND_ROBIN_EN for round-robin tie-break; default is fixed dbus priority.
module vermibus_arbiter #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic        clk,
   input  logic        reset,
   vermibus_if.slave   bus
);
   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IBUS = 2'd1,
      OWN_DBUS = 2'd2
   } owner_e;

   owner_e owner_q, owner_d;
   owner_e last_q, last_d;
   owner_e sel_c;

   logic                  mem_valid_c;
   logic [ADDR_WIDTH-1:0] mem_address_c;
   logic [STRB_WIDTH-1:0] mem_wstrobe_c;
   logic                  ibus_ready_c;
   logic                  dbus_ready_c;

   // Bus selection: a locked owner is never preempted; otherwise arbitrate this cycle.
   always_comb begin
      sel_c = OWN_NONE;
      case (owner_q)
         OWN_IBUS: sel_c = OWN_IBUS;
         OWN_DBUS: sel_c = OWN_DBUS;
         default: begin
            if (bus.ibus_valid && bus.dbus_valid) begin
`ifdef VERMIBUS_ARBITER_ROUND_ROBIN_EN
               sel_c = (last_q == OWN_DBUS) ? OWN_IBUS : OWN_DBUS;
`else
               sel_c = OWN_DBUS;
`endif
            end else if (bus.ibus_valid) begin
               sel_c = OWN_IBUS;
            end else if (bus.dbus_valid) begin
               sel_c = OWN_DBUS;
            end
         end
      endcase
   end

   // Request mux; wstrobe is forced to zero unless the data bus is selected.
   always_comb begin
      mem_valid_c   = 1'b0;
      mem_address_c = '0;
      mem_wstrobe_c = '0;
      case (sel_c)
         OWN_IBUS: begin
            mem_valid_c   = bus.ibus_valid;
            mem_address_c = bus.ibus_address;
         end
         OWN_DBUS: begin
            mem_valid_c   = bus.dbus_valid;
            mem_address_c = bus.dbus_address;
            mem_wstrobe_c = bus.dbus_wstrobe;
         end
         default: ;
      endcase
      ibus_ready_c = bus.mem_ready && mem_valid_c && (sel_c == OWN_IBUS);
      dbus_ready_c = bus.mem_ready && mem_valid_c && (sel_c == OWN_DBUS);
   end

   assign bus.mem_valid   = mem_valid_c;
   assign bus.mem_address = mem_address_c;
   assign bus.mem_wstrobe = mem_wstrobe_c;
   assign bus.mem_wdata   = bus.dbus_wdata;
   assign bus.ibus_ready  = ibus_ready_c;
   assign bus.dbus_ready  = dbus_ready_c;
   assign bus.ibus_rdata  = bus.mem_rdata;
   assign bus.dbus_rdata  = bus.mem_rdata;
   assign bus.dbus_irq    = bus.mem_irq;

   // Lock on a stalled transfer, release on completion or when the owner abandons its request.
   always_comb begin
      owner_d = owner_q;
      last_d  = last_q;
      if (mem_valid_c && !bus.mem_ready) begin
         owner_d = sel_c;
      end else if (mem_valid_c && bus.mem_ready) begin
         owner_d = OWN_NONE;
         last_d  = sel_c;
      end else if (owner_q != OWN_NONE) begin
         owner_d = OWN_NONE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         owner_q <= OWN_NONE;
         last_q  <= OWN_IBUS;
      end else begin
         owner_q <= owner_d;
         last_q  <= last_d;
      end
   end
endmodule

// File: tb/tb_vermibus_arbiter.sv
// Directed-vector bench for vermibus_arbiter; expected values are hand-derived per vector.
module tb_vermibus_arbiter;
   logic clk = 1'b0;
   logic reset;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   vermibus_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   vermibus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one edge, then let inputs be changed away from the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.ibus_valid   = 1'b0;
      bus.ibus_address = '0;
      bus.dbus_valid   = 1'b0;
      bus.dbus_address = '0;
      bus.dbus_wstrobe = '0;
      bus.dbus_wdata   = '0;
      bus.mem_rdata    = '0;
      bus.mem_ready    = 1'b0;
      bus.mem_irq      = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   logic exp_d;

   initial begin
      reset = 1'b1;
      idle_inputs();
      step();
      #1;
      check("rst_mem_valid", 64'(bus.mem_valid), 64'd0);
      check("rst_mem_addr",  64'(bus.mem_address), 64'd0);
      check("rst_ibus_rdy",  64'(bus.ibus_ready), 64'd0);
      check("rst_dbus_rdy",  64'(bus.dbus_ready), 64'd0);
      reset = 1'b0;

      // Fetch with two wait states
      bus.ibus_valid   = 1'b1;
      bus.ibus_address = 32'h0000_0004;
      for (int c = 0; c < 3; c++) begin
         if (c == 2) begin
            bus.mem_rdata = 32'h00A0_0213;
            bus.mem_ready = 1'b1;
         end
         #1;
         check("fetch_addr",  64'(bus.mem_address), 64'h4);
         check("fetch_strb",  64'(bus.mem_wstrobe), 64'h0);
         check("fetch_irdy",  64'(bus.ibus_ready), (c == 2) ? 64'd1 : 64'd0);
         check("fetch_drdy",  64'(bus.dbus_ready), 64'd0);
         step();
      end
      check("fetch_rdata", 64'(bus.ibus_rdata), 64'h00A0_0213);
      bus.ibus_valid = 1'b0;
      bus.mem_ready  = 1'b0;

      // Lock hold: dbus arrives while ibus is stalled
      bus.ibus_valid   = 1'b1;
      bus.ibus_address = 32'h0000_0100;
      #1;
      check("lock_addr0", 64'(bus.mem_address), 64'h100);
      step();
      bus.dbus_valid   = 1'b1;
      bus.dbus_address = 32'h0000_A100;
      bus.dbus_wstrobe = 4'b1111;
      bus.dbus_wdata   = 32'h0000_0096;
      #1;
      check("lock_addr1", 64'(bus.mem_address), 64'h100);
      check("lock_strb1", 64'(bus.mem_wstrobe), 64'h0);
      check("lock_drdy1", 64'(bus.dbus_ready), 64'd0);
      step();
      bus.mem_ready = 1'b1;
      #1;
      check("lock_addr2", 64'(bus.mem_address), 64'h100);
      check("lock_irdy2", 64'(bus.ibus_ready), 64'd1);
      check("lock_drdy2", 64'(bus.dbus_ready), 64'd0);
      step();
      bus.ibus_valid = 1'b0;
      #1;
      check("lock_addr3",  64'(bus.mem_address), 64'hA100);
      check("lock_strb3",  64'(bus.mem_wstrobe), 64'hF);
      check("lock_wdata3", 64'(bus.mem_wdata), 64'h96);
      check("lock_drdy3",  64'(bus.dbus_ready), 64'd1);
      step();
      idle_inputs();

      // Simultaneous single-cycle requests right after reset
      do_reset();
      bus.ibus_valid   = 1'b1;
      bus.ibus_address = 32'h0000_0200;
      bus.dbus_valid   = 1'b1;
      bus.dbus_address = 32'h0000_A200;
      bus.mem_ready    = 1'b1;
      for (int c = 0; c < 4; c++) begin
`ifdef VERMIBUS_ARBITER_ROUND_ROBIN_EN
         exp_d = (c % 2 == 0);
`else
         exp_d = 1'b1;
`endif
         #1;
         check("sim_drdy", 64'(bus.dbus_ready), 64'(exp_d));
         check("sim_irdy", 64'(bus.ibus_ready), 64'(!exp_d));
         check("sim_addr", 64'(bus.mem_address), exp_d ? 64'hA200 : 64'h200);
         step();
      end
      idle_inputs();

      // Byte store passes straight through
      bus.dbus_valid   = 1'b1;
      bus.dbus_address = 32'h0000_A102;
      bus.dbus_wstrobe = 4'b0100;
      bus.dbus_wdata   = 32'h9696_9696;
      bus.mem_ready    = 1'b1;
      #1;
      check("bs_valid", 64'(bus.mem_valid), 64'd1);
      check("bs_addr",  64'(bus.mem_address), 64'hA102);
      check("bs_strb",  64'(bus.mem_wstrobe), 64'h4);
      check("bs_wdata", 64'(bus.mem_wdata), 64'h9696_9696);
      check("bs_drdy",  64'(bus.dbus_ready), 64'd1);
      step();
      idle_inputs();

      // Owner abandons its request: one dead cycle, then the other bus is served
      bus.ibus_valid   = 1'b1;
      bus.ibus_address = 32'h0000_0400;
      step();
      bus.ibus_valid   = 1'b0;
      bus.dbus_valid   = 1'b1;
      bus.dbus_address = 32'h0000_A400;
      bus.mem_ready    = 1'b1;
      #1;
      check("drop_valid", 64'(bus.mem_valid), 64'd0);
      check("drop_drdy",  64'(bus.dbus_ready), 64'd0);
      step();
      #1;
      check("drop_addr2", 64'(bus.mem_address), 64'hA400);
      check("drop_drdy2", 64'(bus.dbus_ready), 64'd1);
      step();
      idle_inputs();

      // Reset while dbus is locked, with irq toggling through it
      bus.dbus_valid   = 1'b1;
      bus.dbus_address = 32'h0000_A300;
      step();
      bus.ibus_valid   = 1'b1;
      bus.ibus_address = 32'h0000_0300;
      bus.mem_irq      = 1'b1;
      #1;
      check("rl_locked_addr", 64'(bus.mem_address), 64'hA300);
      check("irq_hi",         64'(bus.dbus_irq), 64'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      bus.dbus_valid = 1'b0;
      bus.mem_irq    = 1'b0;
      #1;
      check("rl_addr",  64'(bus.mem_address), 64'h300);
      check("rl_drdy",  64'(bus.dbus_ready), 64'd0);
      check("irq_lo",   64'(bus.dbus_irq), 64'd0);
      reset = 1'b1;
      bus.mem_irq = 1'b1;
      #1;
      check("irq_rst",  64'(bus.dbus_irq), 64'd1);
      step();
      reset = 1'b0;
      idle_inputs();
      #1;
      check("irq_rst_lo", 64'(bus.dbus_irq), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/vermibus_arbiter.md
Name: vermibus_arbiter

Overview:
- Merges the Vermicel core's instruction bus and data bus onto one memory/peripheral bus.
- Sits directly downstream of the core (`ibus` read-only requester, `dbus` read-write requester) and upstream of memory and the interconnect.
- Replaces the purely combinational "ibus wins" merge with a locking arbiter: a grant is held until its transfer completes.
- Makes the merge safe for the pipelined core, where both busses may request in the same cycle.

Parameters:
- ADDR_WIDTH, 32, address width of all three busses.
- DATA_WIDTH, 32, data width; wstrobe width is DATA_WIDTH/8.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ibus_valid  in  1  instruction fetch request.
- ibus_address  in  ADDR_WIDTH  fetch address.
- ibus_rdata  out  DATA_WIDTH  fetch read data.
- ibus_ready  out  1  fetch completion.
- dbus_valid  in  1  data request.
- dbus_address  in  ADDR_WIDTH  data address.
- dbus_wstrobe  in  DATA_WIDTH/8  byte write enables; 0 means read.
- dbus_wdata  in  DATA_WIDTH  write data.
- dbus_rdata  out  DATA_WIDTH  load data.
- dbus_ready  out  1  data completion.
- dbus_irq  out  1  interrupt request to the core.
- mem_valid  out  1  merged request.
- mem_address  out  ADDR_WIDTH  merged address.
- mem_wstrobe  out  DATA_WIDTH/8  merged byte enables.
- mem_wdata  out  DATA_WIDTH  merged write data.
- mem_rdata  in  DATA_WIDTH  response data.
- mem_ready  in  1  response completion.
- mem_irq  in  1  interrupt from the system.

Behaviour:
- Clocking: one clock `clk`. Reset `reset` is synchronous and active-high.
- State register `owner`: NONE, IBUS, DBUS. Reset value NONE.
- Register `last` (last granted bus): reset value IBUS.
- Selection while owner=NONE (combinational, zero latency):
  - If exactly one of ibus_valid/dbus_valid is high, select it.
  - If both are high, the priority rule selects one; see Optional Feature.
- Selection while owner=IBUS or DBUS: select owner regardless of the other valid.
- Outputs of the selected bus:
  - mem_valid = selected valid.
  - mem_address = selected address.
  - mem_wdata = dbus_wdata.
  - mem_wstrobe = dbus_wstrobe when DBUS is selected, else 0.
- Outputs when nothing is selected: mem_valid=0, mem_address=0, mem_wstrobe=0.
- Ready routing: selected_ready = mem_ready & mem_valid, routed only to the selected bus. The other bus's ready is 0.
- rdata: ibus_rdata and dbus_rdata both equal mem_rdata at all times.
- dbus_irq = mem_irq, passed through and never gated.
- Transitions (evaluated at the clock edge, reset has priority):
  - mem_valid & !mem_ready: owner <= selected (lock).
  - mem_valid & mem_ready: owner <= NONE and last <= selected. A completed transfer is never re-locked, so back-to-back single-cycle transfers re-arbitrate every cycle.
  - owner != NONE & owner's valid = 0: owner <= NONE. This is a protocol-violation recovery; no ready is issued.
- Requester rule: a requester keeps valid/address/wstrobe/wdata stable until it sees ready. The arbiter does not register request fields.
- Reset mid-transfer: owner <= NONE and last <= IBUS on the next edge. The memory side must tolerate the request being dropped.
- Outputs during reset are combinational from the current state and inputs. After the first reset edge, all ready outputs are 0 until a new grant.
- Latency: 0 added cycles. A zero-wait-state memory completes each transfer in the same cycle it is presented.

Optional Feature:
- Macro: VERMIBUS_ARBITER_ROUND_ROBIN_EN.
- Defined: on a simultaneous request with owner=NONE, the bus not equal to `last` wins. After reset with both valid, DBUS wins (last=IBUS).
- Undefined: fixed priority, DBUS always wins a simultaneous request. `last` is still maintained but unused, which lets the pipelined core drain a load/store before the next fetch.
- In both modes, a locked owner is never preempted.

Test Plan:
- Reset; ibus_valid=1, ibus_address=0x00000004, mem_ready=0 for 2 cycles, then mem_rdata=0x00A00213 and mem_ready=1 → mem_address=0x00000004 and mem_wstrobe=0000 throughout; ibus_ready=1 only in the last cycle with ibus_rdata=0x00A00213; dbus_ready=0 throughout.
- Lock hold: ibus is locked (mem_ready=0). Raise dbus_valid with address 0x0000A100, wstrobe 1111, wdata 0x00000096 → mem_address stays at the ibus address until ibus_ready. On the next cycle mem_address=0x0000A100, mem_wstrobe=1111, mem_wdata=0x00000096.
- Simultaneous requests with mem_ready=1 every cycle, fixed mode → DBUS granted every cycle while dbus_valid=1. Round-robin mode → grants alternate D, I, D, I, starting with D after reset.
- Byte store: dbus_wstrobe=0100, address 0x0000A102, wdata 0x96969696, mem_ready=1 → passed unchanged to mem_* in the same cycle; dbus_ready=1 the same cycle.
- Reset asserted while DBUS is locked (mem_ready=0) → the next cycle has owner=NONE and dbus_ready=0. With only ibus_valid=1 afterwards, mem_address=ibus_address.
- mem_irq toggled 0→1→0 in arbitrary states, including during reset → dbus_irq follows in the same cycle.
